// File: rtl/dm9000a_reg_sequencer.sv
// rtl/dm9000a_reg_sequencer.sv - two-port INDEX/DATA register access sequencer for the DM9000A bus core
//
// Optional feature macro: DM9000A_SEQ_INDEX_CACHE_EN (skip the index phase when the index is unchanged)
// Parameters: PULSE_CYC (strobe low cycles per phase, 1..255), GAP_CYC (recovery cycles per phase, 1..255)
// Ports:
//   iCLK, iRST_N                          clock, asynchronous active-low reset
//   iA_REQ/iA_WE/iA_IDX/iA_WDATA          port A request, direction, register index, write data
//   oA_ACK/oA_RDATA                       port A completion pulse and read data
//   iB_* / oB_*                           same for port B
//   oCMD/oCS_N/oRD_N/oWR_N/oDATA          registered pins to the interface core
//   iDATA                                 read data from the interface core
//   oBUSY                                 high whenever the sequencer is not idle
module dm9000a_reg_sequencer #(
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iA_REQ,
    input  logic        iA_WE,
    input  logic [7:0]  iA_IDX,
    input  logic [15:0] iA_WDATA,
    output logic        oA_ACK,
    output logic [15:0] oA_RDATA,
    input  logic        iB_REQ,
    input  logic        iB_WE,
    input  logic [7:0]  iB_IDX,
    input  logic [15:0] iB_WDATA,
    output logic        oB_ACK,
    output logic [15:0] oB_RDATA,
    output logic        oCMD,
    output logic        oCS_N,
    output logic        oRD_N,
    output logic        oWR_N,
    output logic [15:0] oDATA,
    input  logic [15:0] iDATA,
    output logic        oBUSY
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_IDX_ASSERT = 3'd1;
    localparam logic [2:0] S_IDX_GAP    = 3'd2;
    localparam logic [2:0] S_DAT_ASSERT = 3'd3;
    localparam logic [2:0] S_DAT_GAP    = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

    logic [2:0]  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        last_b;        // 1 = B was granted last, so A wins a tie
    logic        grant_b;
    logic        we_r;
    logic [7:0]  idx_r;
    logic [15:0] wdata_r;
    logic [15:0] rd_cap;

    logic        any_req, pick_b, idx_hit;
    logic        sel_we, nxt_we;
    logic [7:0]  sel_idx, nxt_idx;
    logic [15:0] sel_wdata, nxt_wdata;
    logic        cmd_d, cs_n_d, rd_n_d, wr_n_d;
    logic [15:0] data_d;

`ifdef DM9000A_SEQ_INDEX_CACHE_EN
    logic [7:0] cache_idx;
    logic       cache_valid;

    assign idx_hit = cache_valid && (cache_idx == sel_idx);

    // The core only needs a new index when it differs from the one last written.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cache_idx   <= 8'h00;
            cache_valid <= 1'b0;
        end else if (state == S_IDLE && any_req && !idx_hit) begin
            cache_idx   <= sel_idx;
            cache_valid <= 1'b1;
        end
    end
`else
    assign idx_hit = 1'b0;
`endif

    always_comb begin
        any_req   = iA_REQ | iB_REQ;
        pick_b    = iB_REQ & (~iA_REQ | ~last_b);
        sel_we    = pick_b ? iB_WE    : iA_WE;
        sel_idx   = pick_b ? iB_IDX   : iA_IDX;
        sel_wdata = pick_b ? iB_WDATA : iA_WDATA;

        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = idx_hit ? S_DAT_ASSERT : S_IDX_ASSERT;
                    cnt_nxt   = PULSE_LOAD;
                end
            end
            S_IDX_ASSERT: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_IDX_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_IDX_GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_DAT_ASSERT;
                    cnt_nxt   = PULSE_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DAT_ASSERT: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_DAT_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DAT_GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase

        // Pins are registered from the next state, so the request fields are
        // taken straight from the winner on the grant cycle and from the
        // latched copy afterwards.
        nxt_we    = (state == S_IDLE) ? sel_we    : we_r;
        nxt_idx   = (state == S_IDLE) ? sel_idx   : idx_r;
        nxt_wdata = (state == S_IDLE) ? sel_wdata : wdata_r;

        cmd_d  = (state_nxt == S_DAT_ASSERT) || (state_nxt == S_DAT_GAP);
        cs_n_d = !((state_nxt == S_IDX_ASSERT) || (state_nxt == S_DAT_ASSERT));
        wr_n_d = !((state_nxt == S_IDX_ASSERT) || ((state_nxt == S_DAT_ASSERT) && nxt_we));
        rd_n_d = !((state_nxt == S_DAT_ASSERT) && !nxt_we);
        if (state_nxt == S_IDX_ASSERT) begin
            data_d = {8'h00, nxt_idx};
        end else if ((state_nxt == S_DAT_ASSERT) && nxt_we) begin
            data_d = nxt_wdata;
        end else begin
            data_d = 16'h0000;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            last_b   <= 1'b1;
            grant_b  <= 1'b0;
            we_r     <= 1'b0;
            idx_r    <= 8'h00;
            wdata_r  <= 16'h0000;
            rd_cap   <= 16'h0000;
            oCMD     <= 1'b0;
            oCS_N    <= 1'b1;
            oRD_N    <= 1'b1;
            oWR_N    <= 1'b1;
            oDATA    <= 16'h0000;
            oBUSY    <= 1'b0;
            oA_ACK   <= 1'b0;
            oB_ACK   <= 1'b0;
            oA_RDATA <= 16'h0000;
            oB_RDATA <= 16'h0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && any_req) begin
                grant_b <= pick_b;
                we_r    <= sel_we;
                idx_r   <= sel_idx;
                wdata_r <= sel_wdata;
            end
            if (state == S_DAT_ASSERT && cnt == 8'd0 && !we_r) begin
                rd_cap <= iDATA;
            end
            if (state == S_DONE) begin
                last_b <= grant_b;
            end
            oCMD   <= cmd_d;
            oCS_N  <= cs_n_d;
            oRD_N  <= rd_n_d;
            oWR_N  <= wr_n_d;
            oDATA  <= data_d;
            oBUSY  <= (state_nxt != S_IDLE);
            oA_ACK <= (state_nxt == S_DONE) && !grant_b;
            oB_ACK <= (state_nxt == S_DONE) && grant_b;
            if (state_nxt == S_DONE && !we_r) begin
                if (grant_b) begin
                    oB_RDATA <= rd_cap;
                end else begin
                    oA_RDATA <= rd_cap;
                end
            end
        end
    end

endmodule
